// File: rtl/dflow_replay_ctrl.sv
// Store/replay sequencing for the QDR dataflow path: edge-triggered commands,
// window latching, status counters and a timed datapath soft reset.
module dflow_replay_ctrl #(
  parameter int QDR_ADDR_WIDTH = 19,
  parameter int CNT_WIDTH      = 32,
  parameter int SW_RST_CYCLES  = 16
) (
  input  logic                      qdr_clk,
  input  logic                      resetn,
  input  logic                      init_calib_complete,
  input  logic                      cmd_sw_rst,
  input  logic                      cmd_store,
  input  logic                      cmd_replay,
  input  logic [QDR_ADDR_WIDTH-1:0] cfg_addr_low,
  input  logic [QDR_ADDR_WIDTH-1:0] cfg_addr_high,
  input  logic [CNT_WIDTH-1:0]      store_target,
  input  logic                      tuple_in_vld,
  input  logic                      tuple_in_ready,
  input  logic                      compelete_replay,
  output logic                      sync_sw_rst,
  output logic                      start_store,
  output logic                      start_replay,
  output logic [QDR_ADDR_WIDTH-1:0] mem_addr_low,
  output logic [QDR_ADDR_WIDTH-1:0] mem_addr_high,
  output logic [CNT_WIDTH-1:0]      stored_cnt,
  output logic [CNT_WIDTH-1:0]      replay_cycles,
  output logic [2:0]                state,
  output logic                      err_cfg
);

  localparam int SW_W = (SW_RST_CYCLES > 2) ? $clog2(SW_RST_CYCLES) : 1;
  localparam logic [SW_W-1:0] SW_LAST = SW_W'(SW_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CAL = 3'd1,
    STORE    = 3'd2,
    REPLAY   = 3'd3,
    DONE     = 3'd4,
    SWRST    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            sw_rst_q, store_q, replay_q;
  logic            edge_arm_q;
  logic [SW_W-1:0] sw_cnt;
  logic            sw_edge, store_edge, replay_edge;
  logic            store_accept, err_set;
  logic            handshake;

  // Edges are masked for the first cycle after reset so a held level is
  // absorbed into the history registers instead of firing a command.
  assign sw_edge     = edge_arm_q & cmd_sw_rst & ~sw_rst_q;
  assign store_edge  = edge_arm_q & cmd_store  & ~store_q;
  assign replay_edge = edge_arm_q & cmd_replay & ~replay_q;
  assign handshake   = tuple_in_vld & tuple_in_ready;

  assign state        = state_q;
  assign start_store  = (state_q == STORE);
  assign start_replay = (state_q == REPLAY);
  assign sync_sw_rst  = (state_q == SWRST);

  always_comb begin
    state_d      = state_q;
    store_accept = 1'b0;
    err_set      = 1'b0;
    if (sw_edge) begin
      state_d = SWRST;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (store_edge) begin
            if (cfg_addr_low > cfg_addr_high) begin
              err_set = 1'b1;
            end else begin
              store_accept = 1'b1;
              state_d      = init_calib_complete ? STORE : WAIT_CAL;
            end
          end else if (replay_edge && (stored_cnt != '0)) begin
            state_d = REPLAY;
          end
        end
        WAIT_CAL: if (init_calib_complete) state_d = STORE;
        STORE: begin
          if (replay_edge && (stored_cnt != '0))
            state_d = REPLAY;
          else if ((store_target != '0) && (stored_cnt >= store_target))
            state_d = IDLE;
        end
        REPLAY: if (compelete_replay) state_d = DONE;
        SWRST:  if (sw_cnt == SW_LAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge qdr_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      sw_rst_q      <= 1'b0;
      store_q       <= 1'b0;
      replay_q      <= 1'b0;
      edge_arm_q    <= 1'b0;
      sw_cnt        <= '0;
      mem_addr_low  <= '0;
      mem_addr_high <= '0;
      stored_cnt    <= '0;
      replay_cycles <= '0;
      err_cfg       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_rst_q   <= cmd_sw_rst;
      store_q    <= cmd_store;
      replay_q   <= cmd_replay;
      edge_arm_q <= 1'b1;

      if (sw_edge)
        sw_cnt <= '0;
      else if (state_q == SWRST)
        sw_cnt <= sw_cnt + 1'b1;

      if (store_accept) begin
        mem_addr_low  <= cfg_addr_low;
        mem_addr_high <= cfg_addr_high;
      end

      // The soft reset wins over any counting in the same cycle.
      if (state_d == SWRST)
        stored_cnt <= '0;
      else if (store_accept)
        stored_cnt <= '0;
      else if ((state_q == STORE) && handshake && (stored_cnt != '1))
        stored_cnt <= stored_cnt + 1'b1;

      if (state_d == SWRST)
        replay_cycles <= '0;
      else if ((state_d == REPLAY) && (state_q != REPLAY))
        replay_cycles <= '0;
      else if ((state_q == REPLAY) && (replay_cycles != '1))
        replay_cycles <= replay_cycles + 1'b1;

      if (state_d == SWRST)
        err_cfg <= 1'b0;
      else if (err_set)
        err_cfg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dflow_replay_ctrl.sv
// Directed bench for dflow_replay_ctrl: a vector table for the basic store and
// bad-window flow, then hand sequences for the multi-cycle corner cases.
module tb_dflow_replay_ctrl;

  localparam int AW = 19;
  localparam int CW = 32;

  logic          qdr_clk = 1'b0;
  logic          resetn;
  logic          init_calib_complete;
  logic          cmd_sw_rst, cmd_store, cmd_replay;
  logic [AW-1:0] cfg_addr_low, cfg_addr_high;
  logic [CW-1:0] store_target;
  logic          tuple_in_vld, tuple_in_ready;
  logic          compelete_replay;
  logic          sync_sw_rst, start_store, start_replay;
  logic [AW-1:0] mem_addr_low, mem_addr_high;
  logic [CW-1:0] stored_cnt, replay_cycles;
  logic [2:0]    state;
  logic          err_cfg;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 qdr_clk = ~qdr_clk;

  dflow_replay_ctrl #(
    .QDR_ADDR_WIDTH(AW),
    .CNT_WIDTH(CW),
    .SW_RST_CYCLES(16)
  ) dut (
    .qdr_clk(qdr_clk),
    .resetn(resetn),
    .init_calib_complete(init_calib_complete),
    .cmd_sw_rst(cmd_sw_rst),
    .cmd_store(cmd_store),
    .cmd_replay(cmd_replay),
    .cfg_addr_low(cfg_addr_low),
    .cfg_addr_high(cfg_addr_high),
    .store_target(store_target),
    .tuple_in_vld(tuple_in_vld),
    .tuple_in_ready(tuple_in_ready),
    .compelete_replay(compelete_replay),
    .sync_sw_rst(sync_sw_rst),
    .start_store(start_store),
    .start_replay(start_replay),
    .mem_addr_low(mem_addr_low),
    .mem_addr_high(mem_addr_high),
    .stored_cnt(stored_cnt),
    .replay_cycles(replay_cycles),
    .state(state),
    .err_cfg(err_cfg)
  );

  typedef struct {
    logic          sw, st, rp, cal;
    logic [AW-1:0] lo, hi;
    logic [CW-1:0] tgt;
    logic          hs, cmp;
    logic [2:0]    e_state;
    logic [CW-1:0] e_stored;
    logic          e_ss, e_sr, e_sync, e_err;
    logic [AW-1:0] e_lo, e_hi;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge qdr_clk);
    @(negedge qdr_clk);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    cmd_sw_rst          = v.sw;
    cmd_store           = v.st;
    cmd_replay          = v.rp;
    init_calib_complete = v.cal;
    cfg_addr_low        = v.lo;
    cfg_addr_high       = v.hi;
    store_target        = v.tgt;
    tuple_in_vld        = v.hs;
    tuple_in_ready      = v.hs;
    compelete_replay    = v.cmp;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("v%0d state", idx), 128'(state), 128'(v.e_state));
    check($sformatf("v%0d stored_cnt", idx), 128'(stored_cnt), 128'(v.e_stored));
    check($sformatf("v%0d starts", idx), 128'({start_store, start_replay, sync_sw_rst}),
          128'({v.e_ss, v.e_sr, v.e_sync}));
    check($sformatf("v%0d err_cfg", idx), 128'(err_cfg), 128'(v.e_err));
    check($sformatf("v%0d mem_addr", idx), 128'({mem_addr_low, mem_addr_high}),
          128'({v.e_lo, v.e_hi}));
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({sync_sw_rst, start_store, start_replay, mem_addr_low, mem_addr_high,
                 stored_cnt, replay_cycles, state, err_cfg});
  endfunction

  initial begin
    int cnt;

    // sw st rp cal lo hi tgt hs cmp | state stored ss sr sync err lo hi
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 19'h100, 19'h1FF, 32'd3, 1'b0, 1'b0,
                3'd2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 19'h100, 19'h1FF};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 19'h100, 19'h1FF, 32'd3, 1'b1, 1'b0,
                3'd2, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h100, 19'h1FF};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 19'h100, 19'h1FF, 32'd3, 1'b1, 1'b0,
                3'd2, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 19'h100, 19'h1FF};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 19'h100, 19'h1FF, 32'd3, 1'b1, 1'b0,
                3'd2, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 19'h100, 19'h1FF};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 19'h100, 19'h1FF, 32'd3, 1'b0, 1'b0,
                3'd0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 19'h100, 19'h1FF};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 19'h200, 19'h100, 32'd3, 1'b0, 1'b0,
                3'd0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 19'h100, 19'h1FF};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 19'h200, 19'h100, 32'd3, 1'b0, 1'b0,
                3'd0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 19'h100, 19'h1FF};

    resetn = 1'b0;
    apply_stimulus('{1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 32'd0, 1'b0, 1'b0,
                     3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 19'h0});
    #3;
    check("reset outputs before clock", all_outputs(), 128'd0);
    repeat (2) @(negedge qdr_clk);
    check("reset outputs after clocks", all_outputs(), 128'd0);
    resetn = 1'b1;
    repeat (2) tick();

    // Basic store with target 3, then a reversed window.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
      tick();
      check_output(vecs[i], i);
    end

    // Soft reset and store edge in the same cycle: soft reset wins.
    cmd_sw_rst = 1'b1;
    cmd_store  = 1'b1;
    tick();
    check("swrst entry state", 128'(state), 128'd5);
    check("swrst clears err/stored", 128'({err_cfg, stored_cnt}), 128'd0);
    cnt = 0;
    while (sync_sw_rst && cnt < 40) begin
      cnt++;
      tick();
    end
    check("sync_sw_rst length", 128'(cnt), 128'd16);
    check("swrst exit state", 128'(state), 128'd0);
    check("swrst keeps window", 128'({mem_addr_low, mem_addr_high}), 128'({19'h100, 19'h1FF}));
    cmd_sw_rst = 1'b0;
    cmd_store  = 1'b0;
    tick();

    // Replay edge with nothing stored is ignored.
    cmd_replay = 1'b1;
    tick();
    check("replay with stored 0", 128'({state, start_replay}), 128'd0);
    cmd_replay = 1'b0;
    tick();

    // Store while calibration is pending.
    init_calib_complete = 1'b0;
    cfg_addr_low  = 19'h10;
    cfg_addr_high = 19'h20;
    store_target  = 32'd0;
    cmd_store     = 1'b1;
    tick();
    check("wait_cal entry", 128'({state, start_store}), 128'({3'd1, 1'b0}));
    check("wait_cal window", 128'({mem_addr_low, mem_addr_high}), 128'({19'h10, 19'h20}));
    cmd_store = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cmd_replay = (i == 3);
      tick();
    end
    check("wait_cal holds", 128'(state), 128'd1);
    init_calib_complete = 1'b1;
    tick();
    check("wait_cal to store", 128'({state, start_store}), 128'({3'd2, 1'b1}));

    // Unlimited store of 5 tuples, then a 20-cycle replay.
    tuple_in_vld   = 1'b1;
    tuple_in_ready = 1'b1;
    repeat (5) tick();
    tuple_in_vld   = 1'b0;
    tuple_in_ready = 1'b0;
    tick();
    check("unlimited store count", 128'({state, stored_cnt}), 128'({3'd2, 32'd5}));
    cmd_replay = 1'b1;
    tick();
    check("replay entry", 128'({state, start_store, start_replay, replay_cycles}),
          128'({3'd3, 1'b0, 1'b1, 32'd0}));
    cmd_replay = 1'b0;
    for (int i = 0; i < 19; i++) begin
      cmd_store = (i == 5);
      tick();
    end
    check("replay ignores store edge", 128'({state, replay_cycles}), 128'({3'd3, 32'd19}));
    compelete_replay = 1'b1;
    tick();
    check("replay done", 128'({state, start_replay, replay_cycles}), 128'({3'd4, 1'b0, 32'd20}));
    compelete_replay = 1'b0;

    // Replay edge beats a same-cycle target hit; that handshake still counts.
    cfg_addr_low  = 19'h40;
    cfg_addr_high = 19'h80;
    store_target  = 32'd2;
    cmd_store     = 1'b1;
    tick();
    check("store from done", 128'({state, stored_cnt, mem_addr_low, mem_addr_high}),
          128'({3'd2, 32'd0, 19'h40, 19'h80}));
    cmd_store      = 1'b0;
    tuple_in_vld   = 1'b1;
    tuple_in_ready = 1'b1;
    repeat (2) tick();
    check("target reached", 128'({state, stored_cnt}), 128'({3'd2, 32'd2}));
    cmd_replay = 1'b1;
    tick();
    check("replay wins over hit", 128'({state, stored_cnt}), 128'({3'd3, 32'd3}));
    cmd_replay       = 1'b0;
    tuple_in_vld     = 1'b0;
    tuple_in_ready   = 1'b0;
    compelete_replay = 1'b1;
    tick();
    check("second replay done", 128'(state), 128'd4);
    compelete_replay = 1'b0;

    // Reset mid-replay, then release with the replay command still high.
    cmd_replay = 1'b1;
    tick();
    check("replay before reset", 128'({state, start_replay}), 128'({3'd3, 1'b1}));
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check("async reset mid-replay", all_outputs(), 128'd0);
    @(negedge qdr_clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("no replay after reset %0d", i), 128'({state, start_replay}), 128'd0);
    end
    cmd_replay = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
